mem_bus_arbiter: RTL and testbench

//  Shares the single 6-bit-address / 8-bit-data program memory between the CPU
//  (rd_mem/wr_mem master) and a test/program loader port. Sits between CPU and memory.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 18 +
 rtl/mem_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the CPU/loader program-memory arbiter.
// FSM encodings, owner IDs and the latency-counter width helper.
package mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StAccess = 2'd1;
  localparam state_t StResp   = 2'd2;

  localparam logic OwnCpu = 1'b0;
  localparam logic OwnLd  = 1'b1;

  localparam int unsigned MaxLat = 7;

  // Counter must hold MEM_LAT-1; at least one bit even for MEM_LAT=1.
  function automatic int unsigned lat_width(input int unsigned lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that was not granted last wins.
// Bit 0 is the CPU, bit 1 the loader; purely combinational.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == OwnLd) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises CPU and loader accesses onto one program memory with MEM_LAT strobe cycles,
// returning a one-cycle ack and stalling the CPU through cpu_wait.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADR_W   = 6,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MEM_LAT = 1   // legal 1..MaxLat
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADR_W-1:0]  cpu_adr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADR_W-1:0]  ld_adr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ack,
  output logic [ADR_W-1:0]  mem_adr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              proto_err
);

  localparam int unsigned    LatW    = lat_width(MEM_LAT);
  localparam logic [LatW-1:0] LatInit = LatW'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [ADR_W-1:0]  mem_adr_q, mem_adr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              proto_err_q, proto_err_d;

  logic       cpu_req;
  logic [1:0] gnt;
  logic       sel_we;

  assign cpu_req = cpu_rd | cpu_wr;

  rr_arb2 u_rr_arb2 (
    .req  ({ld_req, cpu_req}),
    .last (last_q),
    .gnt  (gnt)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    lat_cnt_d   = lat_cnt_q;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    proto_err_d = proto_err_q;
    sel_we      = 1'b0;

    case (state_q)
      StIdle: begin
        if (cpu_rd && cpu_wr) begin
          proto_err_d = 1'b1;
        end
        if (gnt != 2'b00) begin
          owner_d   = gnt[1];
          last_d    = gnt[1];
          lat_cnt_d = LatInit;
          state_d   = StAccess;
          if (gnt[1]) begin
            mem_adr_d   = ld_adr;
            mem_wdata_d = ld_wdata;
            sel_we      = ld_we;
          end else begin
            mem_adr_d   = cpu_adr;
            mem_wdata_d = cpu_wdata;
            // A simultaneous read+write request degrades to a read.
            sel_we      = cpu_wr & ~cpu_rd;
          end
          mem_rd_d = ~sel_we;
          mem_wr_d = sel_we;
        end
      end
      StAccess: begin
        if (lat_cnt_q == '0) begin
          state_d  = StResp;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (mem_rd_q) begin
            if (owner_q == OwnLd) ld_rdata_d  = mem_rdata;
            else                  cpu_rdata_d = mem_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d  = StIdle;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= OwnCpu;
      last_q      <= OwnLd;
      lat_cnt_q   <= '0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      lat_cnt_q   <= lat_cnt_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign cpu_ack   = (state_q == StResp) && (owner_q == OwnCpu);
  assign ld_ack    = (state_q == StResp) && (owner_q == OwnLd);
  assign cpu_wait  = cpu_req & ~cpu_ack;
  assign busy      = (state_q != StIdle);
  assign cpu_rdata = cpu_rdata_q;
  assign ld_rdata  = ld_rdata_q;
  assign mem_adr   = mem_adr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: per-cycle vector table on a MEM_LAT=1 arbiter plus hand sequences
// for contention, a MEM_LAT=3 loader write and a reset that aborts an access.
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_rd, cpu_wr, ld_req, ld_we;
  logic [5:0] cpu_adr, ld_adr;
  logic [7:0] cpu_wdata, ld_wdata;

  logic [7:0] cpu_rdata_1, ld_rdata_1, mem_wdata_1, mem_rdata_1;
  logic       cpu_ack_1, cpu_wait_1, ld_ack_1, mem_rd_1, mem_wr_1, busy_1, proto_err_1;
  logic [5:0] mem_adr_1;
  logic [7:0] cpu_rdata_3, ld_rdata_3, mem_wdata_3, mem_rdata_3;
  logic       cpu_ack_3, cpu_wait_3, ld_ack_3, mem_rd_3, mem_wr_3, busy_3, proto_err_3;
  logic [5:0] mem_adr_3;

  logic [7:0] mem1 [64];
  logic [7:0] mem3 [64];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADR_W(6), .DATA_W(8), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_1), .cpu_ack(cpu_ack_1), .cpu_wait(cpu_wait_1),
    .ld_req(ld_req), .ld_we(ld_we), .ld_adr(ld_adr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata_1), .ld_ack(ld_ack_1),
    .mem_adr(mem_adr_1), .mem_rd(mem_rd_1), .mem_wr(mem_wr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1), .busy(busy_1), .proto_err(proto_err_1)
  );

  mem_bus_arbiter #(.ADR_W(6), .DATA_W(8), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_3), .cpu_ack(cpu_ack_3), .cpu_wait(cpu_wait_3),
    .ld_req(ld_req), .ld_we(ld_we), .ld_adr(ld_adr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata_3), .ld_ack(ld_ack_3),
    .mem_adr(mem_adr_3), .mem_rd(mem_rd_3), .mem_wr(mem_wr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mem_rdata_3), .busy(busy_3), .proto_err(proto_err_3)
  );

  // Memory models: combinational read, write on each strobe cycle.
  assign mem_rdata_1 = mem1[mem_adr_1];
  assign mem_rdata_3 = mem3[mem_adr_3];
  always @(posedge clk) if (mem_wr_1) mem1[mem_adr_1] <= mem_wdata_1;
  always @(posedge clk) if (mem_wr_3) mem3[mem_adr_3] <= mem_wdata_3;

  typedef struct {
    logic       rst, crd, cwr;
    logic [5:0] cadr;
    logic [7:0] cwd;
    logic       lreq, lwe;
    logic [5:0] ladr;
    logic       mrd, mwr;
    logic [5:0] madr;
    logic       cack;
    logic [7:0] crdata;
    logic       lack;
    logic [7:0] lrdata;
    logic       cwait, busy, perr;
  } vec_t;

  vec_t tbl [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_inputs();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_adr = '0; cpu_wdata = '0;
    ld_req = 1'b0; ld_we = 1'b0; ld_adr = '0; ld_wdata = '0;
  endtask

  // Returns at a falling edge with reset just released.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int grants [10];
    int ng, ncpu, clash, lat;
    logic alt_ok;

    for (int i = 0; i < 64; i++) begin
      mem1[i] = 8'(i);
      mem3[i] = 8'(i);
    end
    mem1[5] = 8'hA7; mem1[6] = 8'h11; mem1[7] = 8'h22;
    mem3[5] = 8'hA7;

    //          rst crd cwr cadr   cwd    lreq lwe ladr   | mrd mwr madr  cack crdata lack lrdata wait busy perr
    tbl[0]  = '{'0, '0, '0, 6'h00, 8'h00, '0, '0, 6'h00,   '0, '0, 6'h00, '0, 8'h00, '0, 8'h00, '0, '0, '0};
    tbl[1]  = '{'0, '1, '0, 6'h05, 8'h00, '0, '0, 6'h00,   '0, '0, 6'h00, '0, 8'h00, '0, 8'h00, '1, '0, '0};
    tbl[2]  = '{'0, '1, '0, 6'h05, 8'h00, '0, '0, 6'h00,   '1, '0, 6'h05, '0, 8'h00, '0, 8'h00, '1, '1, '0};
    tbl[3]  = '{'0, '1, '0, 6'h05, 8'h00, '0, '0, 6'h00,   '0, '0, 6'h05, '1, 8'hA7, '0, 8'h00, '0, '1, '0};
    tbl[4]  = '{'0, '0, '0, 6'h00, 8'h00, '0, '0, 6'h00,   '0, '0, 6'h05, '0, 8'hA7, '0, 8'h00, '0, '0, '0};
    tbl[5]  = '{'1, '0, '0, 6'h00, 8'h00, '0, '0, 6'h00,   '0, '0, 6'h05, '0, 8'hA7, '0, 8'h00, '0, '0, '0};
    tbl[6]  = '{'0, '1, '0, 6'h05, 8'h00, '1, '0, 6'h06,   '0, '0, 6'h00, '0, 8'h00, '0, 8'h00, '1, '0, '0};
    tbl[7]  = '{'0, '1, '0, 6'h05, 8'h00, '1, '0, 6'h06,   '1, '0, 6'h05, '0, 8'h00, '0, 8'h00, '1, '1, '0};
    tbl[8]  = '{'0, '1, '0, 6'h05, 8'h00, '1, '0, 6'h06,   '0, '0, 6'h05, '1, 8'hA7, '0, 8'h00, '0, '1, '0};
    tbl[9]  = '{'0, '1, '0, 6'h05, 8'h00, '1, '0, 6'h06,   '0, '0, 6'h05, '0, 8'hA7, '0, 8'h00, '1, '0, '0};
    tbl[10] = '{'0, '1, '0, 6'h05, 8'h00, '1, '0, 6'h06,   '1, '0, 6'h06, '0, 8'hA7, '0, 8'h00, '1, '1, '0};
    tbl[11] = '{'0, '1, '0, 6'h05, 8'h00, '1, '0, 6'h06,   '0, '0, 6'h06, '0, 8'hA7, '1, 8'h11, '1, '1, '0};
    tbl[12] = '{'0, '1, '0, 6'h05, 8'h00, '1, '0, 6'h06,   '0, '0, 6'h06, '0, 8'hA7, '0, 8'h11, '1, '0, '0};
    tbl[13] = '{'0, '1, '0, 6'h05, 8'h00, '1, '0, 6'h06,   '1, '0, 6'h05, '0, 8'hA7, '0, 8'h11, '1, '1, '0};
    tbl[14] = '{'0, '1, '0, 6'h05, 8'h00, '1, '0, 6'h06,   '0, '0, 6'h05, '1, 8'hA7, '0, 8'h11, '0, '1, '0};
    tbl[15] = '{'1, '0, '0, 6'h00, 8'h00, '0, '0, 6'h00,   '0, '0, 6'h05, '0, 8'hA7, '0, 8'h11, '0, '0, '0};
    tbl[16] = '{'0, '1, '1, 6'h07, 8'h99, '0, '0, 6'h00,   '0, '0, 6'h00, '0, 8'h00, '0, 8'h00, '1, '0, '0};
    tbl[17] = '{'0, '1, '1, 6'h07, 8'h99, '0, '0, 6'h00,   '1, '0, 6'h07, '0, 8'h00, '0, 8'h00, '1, '1, '1};
    tbl[18] = '{'0, '1, '1, 6'h07, 8'h99, '0, '0, 6'h00,   '0, '0, 6'h07, '1, 8'h22, '0, 8'h00, '0, '1, '1};
    tbl[19] = '{'0, '0, '0, 6'h00, 8'h00, '0, '0, 6'h00,   '0, '0, 6'h07, '0, 8'h22, '0, 8'h00, '0, '0, '1};
    tbl[20] = '{'1, '0, '0, 6'h00, 8'h00, '0, '0, 6'h00,   '0, '0, 6'h07, '0, 8'h22, '0, 8'h00, '0, '0, '1};
    tbl[21] = '{'0, '0, '0, 6'h00, 8'h00, '0, '0, 6'h00,   '0, '0, 6'h00, '0, 8'h00, '0, 8'h00, '0, '0, '0};

    reset = 1'b0;
    clear_inputs();
    do_reset();

    // Per-cycle vectors on the MEM_LAT=1 instance.
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      reset = tbl[i].rst; cpu_rd = tbl[i].crd; cpu_wr = tbl[i].cwr;
      cpu_adr = tbl[i].cadr; cpu_wdata = tbl[i].cwd;
      ld_req = tbl[i].lreq; ld_we = tbl[i].lwe; ld_adr = tbl[i].ladr; ld_wdata = '0;
      #1;
      check($sformatf("r%0d mem_rd", i),    32'(mem_rd_1),    32'(tbl[i].mrd));
      check($sformatf("r%0d mem_wr", i),    32'(mem_wr_1),    32'(tbl[i].mwr));
      check($sformatf("r%0d mem_adr", i),   32'(mem_adr_1),   32'(tbl[i].madr));
      check($sformatf("r%0d cpu_ack", i),   32'(cpu_ack_1),   32'(tbl[i].cack));
      check($sformatf("r%0d cpu_rdata", i), 32'(cpu_rdata_1), 32'(tbl[i].crdata));
      check($sformatf("r%0d ld_ack", i),    32'(ld_ack_1),    32'(tbl[i].lack));
      check($sformatf("r%0d ld_rdata", i),  32'(ld_rdata_1),  32'(tbl[i].lrdata));
      check($sformatf("r%0d cpu_wait", i),  32'(cpu_wait_1),  32'(tbl[i].cwait));
      check($sformatf("r%0d busy", i),      32'(busy_1),      32'(tbl[i].busy));
      check($sformatf("r%0d proto_err", i), 32'(proto_err_1), 32'(tbl[i].perr));
    end
    reset = 1'b0;
    check("proto read left mem[7] intact", 32'(mem1[7]), 32'h22);

    // Continuous contention: ten grants must alternate starting with the CPU.
    do_reset();
    cpu_rd = 1'b1; cpu_adr = 6'h05; ld_req = 1'b1; ld_we = 1'b0; ld_adr = 6'h06;
    ng = 0; clash = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); #1;
      if (mem_rd_1 && mem_wr_1) clash++;
      if (ng < 10 && cpu_ack_1) begin grants[ng] = 0; ng++; end
      if (ng < 10 && ld_ack_1)  begin grants[ng] = 1; ng++; end
      if (ng == 10) break;
    end
    ncpu = 0; alt_ok = 1'b1;
    for (int k = 0; k < ng; k++) begin
      if (grants[k] == 0) ncpu++;
      if (k > 0 && grants[k] == grants[k-1]) alt_ok = 1'b0;
    end
    check("contention grant count", 32'(ng), 32'd10);
    check("contention first grant cpu", 32'(grants[0]), 32'd0);
    check("contention alternation", 32'(alt_ok), 32'd1);
    check("contention cpu grants", 32'(ncpu), 32'd5);
    check("contention strobe clash", 32'(clash), 32'd0);
    clear_inputs();

    // MEM_LAT=3 loader write of 0x3C to 0x3F.
    do_reset();
    ld_req = 1'b1; ld_we = 1'b1; ld_adr = 6'h3F; ld_wdata = 8'h3C;
    #1;
    check("lat3 wr T strobe", 32'(mem_wr_3), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      check($sformatf("lat3 wr T+%0d mem_wr", k), 32'(mem_wr_3), 32'd1);
      check($sformatf("lat3 wr T+%0d mem_rd", k), 32'(mem_rd_3), 32'd0);
      check($sformatf("lat3 wr T+%0d adr", k), 32'(mem_adr_3), 32'h3F);
      check($sformatf("lat3 wr T+%0d wdata", k), 32'(mem_wdata_3), 32'h3C);
      check($sformatf("lat3 wr T+%0d ld_ack", k), 32'(ld_ack_3), 32'd0);
    end
    @(negedge clk); #1;
    check("lat3 wr T+4 ld_ack", 32'(ld_ack_3), 32'd1);
    check("lat3 wr T+4 mem_wr", 32'(mem_wr_3), 32'd0);
    check("lat3 wr T+4 ld_rdata unchanged", 32'(ld_rdata_3), 32'h00);
    ld_req = 1'b0;
    @(negedge clk); #1;
    check("lat3 wr mem[63]", 32'(mem3[63]), 32'h3C);
    check("lat3 wr ack single cycle", 32'(ld_ack_3), 32'd0);

    // MEM_LAT=3 CPU read aborted by reset in its second strobe cycle.
    do_reset();
    cpu_rd = 1'b1; cpu_adr = 6'h05;
    @(negedge clk); #1;
    check("abort T+1 mem_rd", 32'(mem_rd_3), 32'd1);
    @(negedge clk); #1;
    check("abort T+2 mem_rd", 32'(mem_rd_3), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort T+3 busy", 32'(busy_3), 32'd0);
    check("abort T+3 mem_rd", 32'(mem_rd_3), 32'd0);
    check("abort T+3 cpu_ack", 32'(cpu_ack_3), 32'd0);
    check("abort T+3 cpu_rdata", 32'(cpu_rdata_3), 32'h00);
    check("abort T+3 cpu_wait", 32'(cpu_wait_3), 32'd1);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); #1;
      if (cpu_ack_3) begin lat = k; break; end
    end
    check("abort regrant ack latency", 32'(lat), 32'd4);
    check("abort regrant cpu_rdata", 32'(cpu_rdata_3), 32'hA7);
    clear_inputs();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
